// File: rtl/stream_sel_reg.sv
// N-channel registered stream selector: picks one valid/ready input by
// explicit select or round-robin and delivers it through one output register.
module stream_sel_reg #(
  parameter  int DATA_SIZE = 32,
  parameter  int CHANNELS  = 4,
  localparam int SEL_W     = $clog2(CHANNELS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS*DATA_SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          mode,
  output logic [DATA_SIZE-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SEL_W-1:0]              grant
);

  logic [SEL_W-1:0] rr_last;
  logic [SEL_W-1:0] cand;
  logic             has_cand;
  logic             load;

  assign load = !out_valid || out_ready;

  // Candidate search; round-robin starts just after the last round-robin grant
  // and wraps modulo CHANNELS so indices >= CHANNELS are never produced.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_sel;
    has_cand = 1'b0;
    cand     = '0;
    idx      = 0;
    idx_sel  = '0;
    if (!mode) begin
      if (int'(sel) < CHANNELS) begin
        if (in_valid[sel]) begin
          has_cand = 1'b1;
          cand     = sel;
        end
      end
    end else begin
      for (int i = 1; i <= CHANNELS; i++) begin
        idx     = (int'(rr_last) + i) % CHANNELS;
        idx_sel = SEL_W'(idx);
        if (!has_cand && in_valid[idx_sel]) begin
          has_cand = 1'b1;
          cand     = idx_sel;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (has_cand) in_ready[cand] = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
      rr_last   <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (has_cand) begin
        out_valid <= 1'b1;
        out_data  <= in_data[cand*DATA_SIZE +: DATA_SIZE];
        grant     <= cand;
        // Fixed-select transfers must not disturb round-robin fairness.
        if (mode) rr_last <= cand;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
